simple_divider: RTL and testbench
=================================

# simple_divider

Iterative signed divider, the inverse of the pipelined multiplier in the pt_feedback datapath. It recovers a gain-scaled quantity by dividing a full-width product-sized dividend by a DSP-sized divisor. The quotient and remainder come out after a fixed latency. Valid/ready handshakes on both sides let it sit between the feedback register bank and downstream scaling logic. Shift-subtract architecture, one quotient bit per clock, no DSP blocks.

## Interface
- WIDTH_N, 42: dividend and quotient width (signed); matches a 24x18 product.
- WIDTH_D, 18: divisor and remainder width (signed).
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  operands valid.
- ready_o  out  1  block idle, can accept operands.
- n_i  in  WIDTH_N  signed dividend.
- d_i  in  WIDTH_D  signed divisor.
- valid_o  out  1  result valid; held until consumed.
- ready_i  in  1  downstream accepts result.
- q_o  out  WIDTH_N  signed quotient.
- r_o  out  WIDTH_D  signed remainder; truncated, sign of dividend.
- div0_o  out  1  divisor was zero; qualified by valid_o.
- ovf_o  out  1  quotient saturated; qualified by valid_o.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: register |n_i|, |d_i| and both signs, load counter with WIDTH_N, go to CALC.
- CALC:
  - Restoring step per cycle: shift partial remainder left by one, bringing in the next dividend MSB.
  - Subtract |d|; if the result is non-negative, keep it and set the quotient bit to 1.
  - Decrement counter; go to FIX when it reaches 0.
  - Partial remainder is WIDTH_D+1 bits unsigned.
- FIX: apply signs, then go to DONE.
  - q = ±|q|, negative iff signs differ.
  - r = ±|r|, negative iff dividend negative.
- DONE:
  - valid_o=1; outputs stable.
  - On ready_i go to IDLE; ready_o rises the following cycle.
- Truncating division: q toward zero; n = q*d + r.
- Divide by zero (d_i==0):
  - Full latency kept; div0_o=1, ovf_o=0, r_o=0.
  - q_o = +max (2^(WIDTH_N-1)-1) if n_i>=0, else −2^(WIDTH_N-1).
- Overflow: n_i = −2^(WIDTH_N-1) with d_i = −1 gives q_o = +max, r_o=0, ovf_o=1.
- valid_i while not in IDLE is ignored; operands are not captured.
- Reset, asynchronous at any point including mid-CALC:
  - State returns to IDLE; any in-flight result is discarded.
  - Reset values: ready_o=1, valid_o=0, q_o=0, r_o=0, div0_o=0, ovf_o=0.

## Timing
- Accept edge = cycle 0.
- CALC occupies cycles 1..WIDTH_N; FIX occupies cycle WIDTH_N+1.
- valid_o high from cycle WIDTH_N+2 (44 at defaults).
- Fixed latency, independent of operand values, zero divisor, or the rounding option.
- With ready_i held high, valid_o lasts 1 cycle and ready_o returns 1 cycle later.
- Throughput: one division per WIDTH_N+3 cycles.
- ready_o and valid_o are never high together.

## Configuration
- SIMPLE_DIVIDER_ROUND_EN defined: quotient rounds to nearest, half away from zero.
  - In FIX: if 2|r| >= |d| and d != 0, then |q| becomes |q|+1 before the sign is applied.
  - r_o stays the truncated remainder.
  - Cannot overflow: |d|=1 always gives r=0.
- Not defined: truncation toward zero only; no rounding comparator.
- Latency is identical in both builds.

## Structure
- Shared package/header simple_divider_pkg holds:
  - State encoding constants (IDLE/CALC/FIX/DONE).
  - Counter width $clog2(WIDTH_N+1).
  - Saturation constants Q_MAX and Q_MIN.
- Natural sub-module: div_step.
  - Combinational restoring step: shift, subtract, select.
  - Inputs: partial remainder, incoming dividend bit, |d|. Outputs: next remainder, quotient bit.
  - Instantiated once and reused per cycle.

## Test plan
- 100/7 -> q=14, r=2, flags 0, valid_o exactly 44 cycles after accept; with ROUND_EN, q=14.
- −15/2 -> q=−7, r=−1; with ROUND_EN, q=−8, r=−1.
- n=−2^41, d=−1 -> q=2^41−1, r=0, ovf_o=1.
- 5/0 -> div0_o=1, q=2^41−1, r=0; −5/0 -> q=−2^41.
- ready_i held low 10 cycles in DONE -> outputs and valid_o stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next cycle.
- rst_i pulsed at cycle 20 of CALC -> ready_o=1, valid_o=0 immediately; next 1000/−3 -> q=−333, r=1.

Source files
------------

// File: rtl/simple_divider_pkg.sv
// simple_divider shared constants: FSM state encoding,
// default widths, counter width and quotient saturation values.
package simple_divider_pkg;

  localparam int N_W   = 42;
  localparam int D_W   = 18;
  localparam int CNT_W = $clog2(N_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N_W-1:0] Q_MAX = {1'b0, {(N_W-1){1'b1}}};
  localparam logic [N_W-1:0] Q_MIN = {1'b1, {(N_W-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit,
// trial-subtract |d|, keep the difference when it does not borrow.
module div_step
  import simple_divider_pkg::*;
#(
  parameter int WIDTH_D = D_W
) (
  input  logic [WIDTH_D:0]   rem_i,
  input  logic               bit_i,
  input  logic [WIDTH_D-1:0] d_i,
  output logic [WIDTH_D:0]   rem_o,
  output logic               q_o
);

  logic [WIDTH_D+1:0] sh;
  logic [WIDTH_D+1:0] diff;

  // Partial remainder stays below |d|, so the shifted
  // value never reaches the top bit and diff's MSB is a clean borrow.
  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh - {2'b00, d_i};
    q_o   = ~diff[WIDTH_D+1];
    rem_o = q_o ? diff[WIDTH_D:0] : sh[WIDTH_D:0];
  end

endmodule

// File: rtl/simple_divider.sv
// Iterative signed shift-subtract divider, one quotient bit per clock.
// Define SIMPLE_DIVIDER_ROUND_EN for round-half-away-from-zero quotients.
module simple_divider
  import simple_divider_pkg::*;
#(
  parameter int WIDTH_N = N_W,
  parameter int WIDTH_D = D_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_N-1:0] n_i,
  input  logic [WIDTH_D-1:0] d_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_N-1:0] q_o,
  output logic [WIDTH_D-1:0] r_o,
  output logic               div0_o,
  output logic               ovf_o
);

  localparam int CW = $clog2(WIDTH_N + 1);

  localparam logic [WIDTH_N-1:0] QMAX =
    {1'b0, {(WIDTH_N-1){1'b1}}};
  localparam logic [WIDTH_N-1:0] QMIN =
    {1'b1, {(WIDTH_N-1){1'b0}}};

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] work;
  logic [WIDTH_D:0]   rem;
  logic [WIDTH_D-1:0] dmag;
  logic               n_neg;
  logic               q_neg;
  logic               zero;
  logic               ovf;

  logic [WIDTH_N-1:0] n_abs;
  logic [WIDTH_D-1:0] d_abs;
  logic               in_zero;
  logic               in_ovf;

  logic [WIDTH_D:0]   rem_nx;
  logic               qbit;

  logic [WIDTH_N-1:0] q_mag;
  logic [WIDTH_N-1:0] q_res;
  logic [WIDTH_D-1:0] r_res;

  assign ready_o = (state == S_IDLE);
  assign valid_o = (state == S_DONE);

  // Operand magnitudes and special-case detection at accept time;
  // the most negative value negates onto its own unsigned magnitude.
  always_comb begin
    n_abs   = n_i[WIDTH_N-1] ? -n_i : n_i;
    d_abs   = d_i[WIDTH_D-1] ? -d_i : d_i;
    in_zero = (d_i == '0);
    in_ovf  = (n_i == QMIN) && (d_i == '1);
  end

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .rem_i (rem),
    .bit_i (work[WIDTH_N-1]),
    .d_i   (dmag),
    .rem_o (rem_nx),
    .q_o   (qbit)
  );

`ifdef SIMPLE_DIVIDER_ROUND_EN
  logic rnd;

  // Round the magnitude up when the truncated remainder is at
  // least half the divisor.
  always_comb begin
    rnd   = ({rem, 1'b0} >= {2'b00, dmag}) && !zero;
    q_mag = work + {{(WIDTH_N-1){1'b0}}, rnd};
  end
`else
  assign q_mag = work;
`endif

  // Sign restore and saturation for divide-by-zero and overflow.
  always_comb begin
    q_res = q_neg ? -q_mag : q_mag;
    r_res = n_neg ? -rem[WIDTH_D-1:0] : rem[WIDTH_D-1:0];
    if (zero) begin
      q_res = n_neg ? QMIN : QMAX;
      r_res = '0;
    end else if (ovf) begin
      q_res = QMAX;
      r_res = '0;
    end
  end

  // Control FSM and the shifting dividend/quotient register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      work  <= '0;
      rem   <= '0;
      dmag  <= '0;
      n_neg <= 1'b0;
      q_neg <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid_i) begin
            state <= S_CALC;
            cnt   <= CW'(WIDTH_N);
            work  <= n_abs;
            rem   <= '0;
            dmag  <= d_abs;
            n_neg <= n_i[WIDTH_N-1];
            q_neg <= n_i[WIDTH_N-1] ^ d_i[WIDTH_D-1];
            zero  <= in_zero;
            ovf   <= in_ovf;
          end
        end
        S_CALC: begin
          work <= {work[WIDTH_N-2:0], qbit};
          rem  <= rem_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers load in FIX and hold through DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o    <= '0;
      r_o    <= '0;
      div0_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (state == S_FIX) begin
      q_o    <= q_res;
      r_o    <= r_res;
      div0_o <= zero;
      ovf_o  <= ovf && !zero;
    end
  end

endmodule

// File: tb/tb_simple_divider.sv
// Self-checking bench for simple_divider: arithmetic reference model,
// per-cycle output compare, and directed literal vectors.
module tb_simple_divider;
  import simple_divider_pkg::*;

  localparam int WN = N_W;
  localparam int WD = D_W;
`ifdef SIMPLE_DIVIDER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam longint QMAX = (longint'(1) <<< (WN-1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (WN-1));

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [WN-1:0] n_i = '0;
  logic [WD-1:0] d_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [WN-1:0] q_o;
  logic [WD-1:0] r_o;
  logic          div0_o;
  logic          ovf_o;

  simple_divider dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .n_i     (n_i),
    .d_i     (d_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .q_o     (q_o),
    .r_o     (r_o),
    .div0_o  (div0_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint q;
    longint r;
    bit     z;
    bit     o;
  } exp_t;

  exp_t   expq[$];
  int     checks = 0;
  int     failures = 0;
  int     edges = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain truncating arithmetic plus the special cases.
  function automatic exp_t model(input longint n, input longint d);
    exp_t e;
    e = '{0, 0, 1'b0, 1'b0};
    if (d == 0) begin
      e.z = 1'b1;
      e.q = (n >= 0) ? QMAX : QMIN;
    end else if (n == QMIN && d == -1) begin
      e.o = 1'b1;
      e.q = QMAX;
    end else begin
      e.q = n / d;
      e.r = n % d;
      if (ROUND && 2 * labs(e.r) >= labs(d))
        e.q = e.q + (((n < 0) != (d < 0)) ? -1 : 1);
    end
    return e;
  endfunction

  function automatic longint sq();
    return longint'($signed(q_o));
  endfunction

  function automatic longint sr();
    return longint'($signed(r_o));
  endfunction

  // Every cycle: exclusivity of ready/valid and outputs vs model.
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("rdy_vld_excl", longint'(valid_o && ready_o), 0);
      if (valid_o) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("mdl_q", sq(), expq[0].q);
          chk("mdl_r", sr(), expq[0].r);
          chk("mdl_div0", longint'(div0_o), longint'(expq[0].z));
          chk("mdl_ovf", longint'(ovf_o), longint'(expq[0].o));
          if (ready_i) void'(expq.pop_front());
        end
      end
    end
  end

  int acc;

  task automatic issue(input longint n, input longint d,
                       input bit push);
    int k;
    k = 0;
    while (!ready_o && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready_o) chk("wait_ready_timeout", 0, 1);
    n_i = n[WN-1:0];
    d_i = d[WD-1:0];
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    acc = edges;
    if (push) expq.push_back(model(n, d));
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!valid_o && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!valid_o) chk("wait_valid_timeout", 0, 1);
    chk("latency", longint'(edges - acc + 1), longint'(WN + 2));
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("ready_after_done", longint'(ready_o), 1);
    chk("valid_after_done", longint'(valid_o), 0);
  endtask

  task automatic lit(input string nm, input longint n,
                     input longint d, input longint eq,
                     input longint er, input bit ez,
                     input bit eo);
    issue(n, d, 1'b1);
    wait_valid();
    chk({nm, "_q"}, sq(), eq);
    chk({nm, "_r"}, sr(), er);
    chk({nm, "_div0"}, longint'(div0_o), longint'(ez));
    chk({nm, "_ovf"}, longint'(ovf_o), longint'(eo));
    consume();
  endtask

  task automatic run(input longint n, input longint d);
    issue(n, d, 1'b1);
    wait_valid();
    consume();
  endtask

  longint nv[8] = '{0, 7, -7, -100, QMAX, QMIN, QMIN, 123456789};
  longint dv[8] = '{5, -2, 2, -7, 1, 1, 131071, -131072};

  initial begin
    exp_t        m;
    logic [63:0] w;
    logic [31:0] u;

    #2;
    chk("rst_ready", longint'(ready_o), 1);
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_q", sq(), 0);
    chk("rst_r", sr(), 0);
    chk("rst_div0", longint'(div0_o), 0);
    chk("rst_ovf", longint'(ovf_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    m = model(100, 7);
    chk("pin_100_7", m.q, 14);
    m = model(-15, 2);
    chk("pin_m15_2", m.q, ROUND ? -8 : -7);
    m = model(1000, -3);
    chk("pin_1000_m3", m.r, 1);

    lit("d100_7", 100, 7, 14, 2, 1'b0, 1'b0);
    lit("dm15_2", -15, 2, ROUND ? -8 : -7, -1, 1'b0, 1'b0);
    lit("ovf", QMIN, -1, QMAX, 0, 1'b0, 1'b1);
    lit("p5_0", 5, 0, QMAX, 0, 1'b1, 1'b0);
    lit("m5_0", -5, 0, QMIN, 0, 1'b1, 1'b0);

    issue(77777, -5, 1'b1);
    wait_valid();
    n_i = 42'd1;
    d_i = 18'd1;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", longint'(valid_o), 1);
      chk("stall_ready", longint'(ready_o), 0);
      chk("stall_q", sq(), -15555);
      chk("stall_r", sr(), 2);
    end
    valid_i = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_op_idle", longint'(ready_o), 1);

    issue(12345, 7, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", longint'(ready_o), 1);
    chk("midrst_valid", longint'(valid_o), 0);
    chk("midrst_q", sq(), 0);
    chk("midrst_r", sr(), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    lit("d1000_m3", 1000, -3, -333, 1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) run(nv[i], dv[i]);
    for (int i = 0; i < 8; i++) begin
      w = {$urandom, $urandom};
      u = $urandom;
      run(longint'($signed(w[WN-1:0])),
          longint'($signed(u[WD-1:0])));
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", longint'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
